// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared framebuffer geometry, fill command record and fill
//                engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int H_RES         = 400;
    localparam int V_RES         = 300;
    localparam int WORDS_PER_ROW = H_RES / 4;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] y0;
        logic [8:0] width;
        logic [8:0] height;
        logic [7:0] color;
    } fill_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLIP  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/fill_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fill_mask_gen
//  Description : Byte-enable for one framebuffer word of a row span; lane k
//                covers pixel x with x[1:0] == k.
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_mask_gen (
    input  logic [1:0] x0_lo,
    input  logic [1:0] x1_m1_lo,
    input  logic       is_first,
    input  logic       is_last,
    output logic [3:0] byte_en
);

    logic [3:0] first_mask;
    logic [3:0] last_mask;

    always_comb begin
        first_mask = 4'b1111 << x0_lo;
        last_mask  = 4'b1111 >> (2'd3 - x1_m1_lo);
        byte_en    = (is_first ? first_mask : 4'b1111) &
                     (is_last  ? last_mask  : 4'b1111);
    end

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_engine
//  Description : Rectangle-fill blitter; clips one command to the 8bpp
//                framebuffer and emits granted 32-bit masked word writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_fill_engine #(
    parameter int          H_RES     = gpu_pkg::WORDS_PER_ROW * 4,
    parameter int          V_RES     = gpu_pkg::V_RES,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        gpu_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_x0,
    input  logic [8:0]  cmd_y0,
    input  logic [8:0]  cmd_width,
    input  logic [8:0]  cmd_height,
    input  logic [7:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic [31:0] fb_address,
    output logic [31:0] fb_wr_data,
    output logic [3:0]  fb_wr_en,
    input  logic        fb_grant
);

    import gpu_pkg::*;

    fill_state_t state_q, state_d;
    fill_cmd_t   cmd_q, cmd_d;
    logic [8:0]  row_q, row_d;
    logic [7:0]  word_q, word_d;
    logic [31:0] row_base_q, row_base_d;
    logic [31:0] fb_address_q, fb_address_d;
    logic [31:0] fb_wr_data_q, fb_wr_data_d;
    logic [3:0]  fb_wr_en_q, fb_wr_en_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;

    logic [9:0]  x_end, y_end, x1, y1, x1_m1;
    logic [7:0]  first_word, last_word, nxt_word;
    logic [31:0] nxt_row_base;
    logic        is_empty, row_last, load;
    logic [3:0]  nxt_mask;

    // Clip bounds are derived from the latched command, which is frozen until DONE.
    always_comb begin
        x_end      = {1'b0, cmd_q.x0} + {1'b0, cmd_q.width};
        y_end      = {1'b0, cmd_q.y0} + {1'b0, cmd_q.height};
        x1         = (x_end > 10'(H_RES)) ? 10'(H_RES) : x_end;
        y1         = (y_end > 10'(V_RES)) ? 10'(V_RES) : y_end;
        x1_m1      = x1 - 10'd1;
        first_word = {1'b0, cmd_q.x0[8:2]};
        last_word  = x1_m1[9:2];
        is_empty   = (cmd_q.width == 9'd0) || (cmd_q.height == 9'd0) ||
                     ({1'b0, cmd_q.x0} >= 10'(H_RES)) ||
                     ({1'b0, cmd_q.y0} >= 10'(V_RES));
        row_last   = (({1'b0, row_q} + 10'd1) == y1);
    end

    fill_mask_gen u_mask (
        .x0_lo    (cmd_q.x0[1:0]),
        .x1_m1_lo (x1_m1[1:0]),
        .is_first (nxt_word == first_word),
        .is_last  (nxt_word == last_word),
        .byte_en  (nxt_mask)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        row_d        = row_q;
        word_d       = word_q;
        row_base_d   = row_base_q;
        fb_address_d = fb_address_q;
        fb_wr_data_d = fb_wr_data_q;
        fb_wr_en_d   = fb_wr_en_q;
        done_d       = 1'b0;
        nxt_word     = word_q;
        nxt_row_base = row_base_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.x0     = cmd_x0;
                    cmd_d.y0     = cmd_y0;
                    cmd_d.width  = cmd_width;
                    cmd_d.height = cmd_height;
                    cmd_d.color  = cmd_color;
                    state_d      = CLIP;
                end
            end
            CLIP: begin
                if (is_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d      = WRITE;
                    row_d        = cmd_q.y0;
                    nxt_word     = first_word;
                    nxt_row_base = BASE_ADDR + 32'(cmd_q.y0) * 32'(H_RES);
                    load         = 1'b1;
                end
            end
            WRITE: begin
                if (fb_grant) begin
                    if (word_q != last_word) begin
                        nxt_word = word_q + 8'd1;
                        load     = 1'b1;
                    end else if (!row_last) begin
                        row_d        = row_q + 9'd1;
                        nxt_word     = first_word;
                        nxt_row_base = row_base_q + 32'(H_RES);
                        load         = 1'b1;
                    end else begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        fb_wr_en_d = 4'b0000;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            word_d       = nxt_word;
            row_base_d   = nxt_row_base;
            fb_address_d = nxt_row_base + {22'd0, nxt_word, 2'b00};
            fb_wr_data_d = {4{cmd_q.color}};
            fb_wr_en_d   = nxt_mask;
        end

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            row_q        <= '0;
            word_q       <= '0;
            row_base_q   <= '0;
            fb_address_q <= '0;
            fb_wr_data_q <= '0;
            fb_wr_en_q   <= '0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            row_q        <= row_d;
            word_q       <= word_d;
            row_base_q   <= row_base_d;
            fb_address_q <= fb_address_d;
            fb_wr_data_q <= fb_wr_data_d;
            fb_wr_en_q   <= fb_wr_en_d;
            done_q       <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fb_address = fb_address_q;
    assign fb_wr_data = fb_wr_data_q;
    assign fb_wr_en   = fb_wr_en_q;

endmodule
`default_nettype wire
